// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback-side initiator for the register file's single write port.
//
// The single-cycle ALU result always has priority. LSU results either go
// straight to the port, when it is free and nothing is queued, or wait in a
// small in-order FIFO until the port is free. Writes are registered, so the
// winner of a cycle appears on we/rd/rd_data at the next rising edge.
//
// Optional feature (macro WB_BYPASS_EN): adds two read-port forwarding taps
// (rs1/rs2 -> fwdN_hit/fwdN_data) fed from the registered write.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   alu_valid/rd/data     ALU result; no backpressure; rd==0 means no write
//   lsu_valid/ready/rd/data
//                         LSU result handshake; rd==0 is accepted and dropped
//   we, rd, rd_data       registered register-file write
//   rd_pending            bit i set while a queued LSU result targets xi
//   fifo_count            current FIFO occupancy
//   rs1, rs2, fwd1_*, fwd2_*  (WB_BYPASS_EN only) forwarding taps
//
// Handshake: an LSU transfer happens on a rising edge where lsu_valid and
// lsu_ready are both 1. lsu_ready depends only on registered state (FIFO not
// full), never on lsu_valid, and the LSU holds its payload until the transfer.
module wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int AW    = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [AW-1:0]            alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [AW-1:0]            lsu_rd,
    input  logic [XLEN-1:0]          lsu_data,
    output logic                     we,
    output logic [AW-1:0]            rd,
    output logic [XLEN-1:0]          rd_data,
    output logic [31:0]              rd_pending,
    output logic [$clog2(DEPTH):0]   fifo_count
`ifdef WB_BYPASS_EN
    ,
    input  logic [AW-1:0]            rs1,
    input  logic [AW-1:0]            rs2,
    output logic                     fwd1_hit,
    output logic [XLEN-1:0]          fwd1_data,
    output logic                     fwd2_hit,
    output logic [XLEN-1:0]          fwd2_data
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // FIFO storage. Entries carry no valid bit: validity follows from head/count.
    logic [AW-1:0]   r_fifo_rd   [DEPTH];
    logic [XLEN-1:0] r_fifo_data [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;

    logic            r_we;
    logic [AW-1:0]   r_rd;
    logic [XLEN-1:0] r_rd_data;

    logic            w_alu_ok;
    logic            w_lsu_hs;
    logic            w_lsu_ok;
    logic            w_empty;
    logic            w_pop;
    logic            w_direct;
    logic            w_push;
    logic [PW-1:0]   w_idx;
    logic [31:0]     w_pending;

    // A write to x0 is architecturally a no-op, so it never claims the port.
    assign w_alu_ok  = alu_valid && (alu_rd != '0);
    assign lsu_ready = (r_count != CW'(DEPTH));
    assign w_lsu_hs  = lsu_valid && lsu_ready;
    assign w_lsu_ok  = w_lsu_hs && (lsu_rd != '0);
    assign w_empty   = (r_count == '0);

    // The direct path is only taken when nothing is queued, which keeps LSU
    // results in acceptance order.
    assign w_pop     = !w_alu_ok && !w_empty;
    assign w_direct  = !w_alu_ok && w_empty && w_lsu_ok;
    assign w_push    = w_lsu_ok && (w_alu_ok || !w_empty);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_we      <= 1'b0;
            r_rd      <= '0;
            r_rd_data <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_alu_ok) begin
                r_we      <= 1'b1;
                r_rd      <= alu_rd;
                r_rd_data <= alu_data;
            end else if (w_pop) begin
                r_we      <= 1'b1;
                r_rd      <= r_fifo_rd[r_head];
                r_rd_data <= r_fifo_data[r_head];
            end else if (w_direct) begin
                r_we      <= 1'b1;
                r_rd      <= lsu_rd;
                r_rd_data <= lsu_data;
            end
            // Pointers are exactly PW bits, so wrap modulo DEPTH is implicit.
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage needs no reset; stale entries are never read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_tail]   <= lsu_rd;
            r_fifo_data[r_tail] <= lsu_data;
        end
    end

    // OR of one-hot destinations over the occupied slots, head onwards.
    always_comb begin
        w_pending = '0;
        w_idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head + PW'(k);
            if (CW'(k) < r_count) begin
                w_pending = w_pending | (32'd1 << r_fifo_rd[w_idx]);
            end
        end
        w_pending[0] = 1'b0;
    end

    assign we         = r_we;
    assign rd         = r_rd;
    assign rd_data    = r_rd_data;
    assign rd_pending = w_pending;
    assign fifo_count = r_count;

`ifdef WB_BYPASS_EN
    // Forward the write the register file is about to absorb.
    assign fwd1_hit  = r_we && (r_rd == rs1) && (rs1 != '0);
    assign fwd2_hit  = r_we && (r_rd == rs2) && (rs2 != '0);
    assign fwd1_data = fwd1_hit ? r_rd_data : '0;
    assign fwd2_data = fwd2_hit ? r_rd_data : '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int AW    = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            alu_valid = 1'b0;
    logic [AW-1:0]   alu_rd    = '0;
    logic [XLEN-1:0] alu_data  = '0;
    logic            lsu_valid = 1'b0;
    logic            lsu_ready;
    logic [AW-1:0]   lsu_rd    = '0;
    logic [XLEN-1:0] lsu_data  = '0;
    logic            we;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] rd_data;
    logic [31:0]     rd_pending;
    logic [2:0]      fifo_count;
`ifdef WB_BYPASS_EN
    logic [AW-1:0]   rs1 = '0;
    logic [AW-1:0]   rs2 = '0;
    logic            fwd1_hit, fwd2_hit;
    logic [XLEN-1:0] fwd1_data, fwd2_data;
`endif

    wb_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .we(we), .rd(rd), .rd_data(rd_data),
        .rd_pending(rd_pending), .fifo_count(fifo_count)
`ifdef WB_BYPASS_EN
        ,
        .rs1(rs1), .rs2(rs2),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
        .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data)
`endif
    );

    // ---------------- scoreboard / reference model ----------------
    int n_checks = 0;
    int n_pass   = 0;

    // Queued LSU results as {rd, data}, oldest first.
    logic [AW+XLEN-1:0] exp_q[$];
    logic               m_we;
    logic [AW-1:0]      m_rd;
    logic [XLEN-1:0]    m_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] m_pending();
        logic [31:0] p = '0;
        foreach (exp_q[i]) p[exp_q[i][AW+XLEN-1:XLEN]] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    function automatic void m_reset();
        exp_q.delete();
        m_we   = 1'b0;
        m_rd   = '0;
        m_data = '0;
    endfunction

    // ---------------- driver tasks ----------------
    // Reset with live traffic on both inputs; nothing may survive it.
    task automatic reset_dut();
        rst       = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h1234;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h5678;
        @(posedge clk); #1;
        rst = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0;
        m_reset();
        chk("rst_we", 64'(we), 64'(0));
        chk("rst_rd", 64'(rd), 64'(0));
        chk("rst_data", 64'(rd_data), 64'(0));
        chk("rst_count", 64'(fifo_count), 64'(0));
        chk("rst_pending", 64'(rd_pending), 64'(0));
        chk("rst_ready", 64'(lsu_ready), 64'(1));
    endtask

    // One cycle: drive, check ready, advance the model, check outputs.
    task automatic step(input logic av, input logic [AW-1:0] ard, input logic [XLEN-1:0] ad,
                        input logic lv, input logic [AW-1:0] lrd, input logic [XLEN-1:0] ld,
                        output logic acc);
        logic rdy, alu_ok, lsu_ok;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        #1;
        rdy = (exp_q.size() != DEPTH);
        chk("lsu_ready", 64'(lsu_ready), 64'(rdy));
        acc    = lv && rdy;
        alu_ok = av && (ard != 0);
        lsu_ok = acc && (lrd != 0);
        m_we   = 1'b0;
        if (alu_ok) begin
            m_we = 1'b1; m_rd = ard; m_data = ad;
            if (lsu_ok) exp_q.push_back({lrd, ld});
        end else if (exp_q.size() != 0) begin
            m_we = 1'b1;
            {m_rd, m_data} = exp_q.pop_front();
            if (lsu_ok) exp_q.push_back({lrd, ld});
        end else if (lsu_ok) begin
            m_we = 1'b1; m_rd = lrd; m_data = ld;
        end
        @(posedge clk); #1;
        chk("we", 64'(we), 64'(m_we));
        chk("rd", 64'(rd), 64'(m_rd));
        chk("rd_data", 64'(rd_data), 64'(m_data));
        chk("fifo_count", 64'(fifo_count), 64'(exp_q.size()));
        chk("rd_pending", 64'(rd_pending), 64'(m_pending()));
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic            av;
        logic [AW-1:0]   ard;
        logic [XLEN-1:0] ad;
        logic            lv;
        logic [AW-1:0]   lrd;
        logic [XLEN-1:0] ld;
        logic            e_we;
        logic [AW-1:0]   e_rd;
        logic [XLEN-1:0] e_data;
        logic [2:0]      e_cnt;
        logic [31:0]     e_pend;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic acc;
        int   lsu_next;
        int   writes[$];

        // direct path, contention, hold, x0 filtering
        vecs[0] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd5, 32'h11111111, 1'b1, 5'd5, 32'h11111111, 3'd0, 32'h0};
        vecs[1] = '{1'b1, 5'd3, 32'hA,  1'b1, 5'd7, 32'hB,        1'b1, 5'd3, 32'hA,        3'd1, 32'h80};
        vecs[2] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'hB,        3'd0, 32'h0};
        vecs[3] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 32'hB,        3'd0, 32'h0};
        vecs[4] = '{1'b1, 5'd0, 32'h55, 1'b1, 5'd9, 32'h99,       1'b1, 5'd9, 32'h99,       3'd0, 32'h0};
        vecs[5] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd0, 32'h77,       1'b0, 5'd9, 32'h99,       3'd0, 32'h0};
        vecs[6] = '{1'b1, 5'd2, 32'h22, 1'b1, 5'd0, 32'h66,       1'b1, 5'd2, 32'h22,       3'd0, 32'h0};
        vecs[7] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,        1'b0, 5'd2, 32'h22,       3'd0, 32'h0};

        reset_dut();
        for (int i = 0; i < 8; i++) begin
            alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].ad;
            lsu_valid = vecs[i].lv; lsu_rd = vecs[i].lrd; lsu_data = vecs[i].ld;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_we", i), 64'(we), 64'(vecs[i].e_we));
            chk($sformatf("vec%0d_rd", i), 64'(rd), 64'(vecs[i].e_rd));
            chk($sformatf("vec%0d_data", i), 64'(rd_data), 64'(vecs[i].e_data));
            chk($sformatf("vec%0d_count", i), 64'(fifo_count), 64'(vecs[i].e_cnt));
            chk($sformatf("vec%0d_pending", i), 64'(rd_pending), 64'(vecs[i].e_pend));
        end

        // Full FIFO: ALU busy for 6 cycles while the LSU offers rd 1..5.
        reset_dut();
        lsu_next = 1;
        for (int c = 0; c < 40 && writes.size() < 5; c++) begin
            if (c == 4) chk("full_stall", 64'(lsu_ready), 64'(0));
            step(c < 6, AW'(20 + c % 8), 32'(c), lsu_next <= 5, AW'(lsu_next),
                 32'h100 + 32'(lsu_next), acc);
            if (acc) lsu_next++;
            if (we && rd < 20) writes.push_back(int'(rd));
        end
        chk("full_nwrites", 64'(writes.size()), 64'(5));
        for (int i = 0; i < 5; i++) begin
            if (i < writes.size()) chk($sformatf("full_order%0d", i), 64'(writes[i]), 64'(i + 1));
        end

        // Reset while results are queued discards them.
        for (int c = 0; c < 3; c++) step(1'b1, 5'd10, 32'(c), 1'b1, AW'(11 + c), 32'(c), acc);
        reset_dut();
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, acc);

`ifdef WB_BYPASS_EN
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hDEAD, acc);
        rs1 = 5'd12; rs2 = 5'd0; #1;
        chk("fwd1_hit", 64'(fwd1_hit), 64'(1));
        chk("fwd1_data", 64'(fwd1_data), 64'(32'hDEAD));
        chk("fwd2_hit", 64'(fwd2_hit), 64'(0));
        chk("fwd2_data", 64'(fwd2_data), 64'(0));
`endif

        // Randomized traffic against the model, with occasional resets.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 199) == 0) reset_dut();
            step($urandom_range(0, 99) < 55, AW'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 99) < 60, AW'($urandom_range(0, 31)), $urandom, acc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
